// File: rtl/seg_vect_pkg.sv
// Shared definitions for the segment-vector TCAM engine: update op codes,
// controller states and the per-segment ternary compare.
package seg_vect_pkg;

  localparam logic [1:0] OP_INS = 2'b00;
  localparam logic [1:0] OP_DEL = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    SWEEP = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Operands are zero-extended by the caller, so the upper bits always compare equal.
  function automatic logic seg_match(input logic [31:0] a,
                                     input logic [31:0] key_s,
                                     input logic [31:0] mask_s);
    return ((a ^ key_s) & ~mask_s) == 32'd0;
  endfunction

endpackage

// File: rtl/seg_vect_bank.sv
// One segment bank: 1R1W synchronous RAM of one-hot entry vectors plus the
// read-modify-write bit-insert stage used by the update sweep.
module seg_vect_bank
  import seg_vect_pkg::*;
#(
  parameter int SEGBITS = 8,
  parameter int NENT    = 64,
  parameter int IDWID   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEGBITS-1:0] rd_addr,
  input  logic               sweep_rd,
  input  logic               init_we,
  input  logic [1:0]         op,
  input  logic [IDWID-1:0]   id,
  input  logic [SEGBITS-1:0] key_s,
  input  logic [SEGBITS-1:0] mask_s,
  output logic [NENT-1:0]    rd_word
);

  localparam int DEPTH = 2 ** SEGBITS;

  logic [NENT-1:0]    mem [DEPTH];
  logic [NENT-1:0]    rdata_q;
  logic [NENT-1:0]    wr_word;
  logic [SEGBITS-1:0] wr_addr_q;
  logic               wr_pend_q;
  logic               m_bit;

  always_ff @(posedge clk) begin
    rdata_q <= mem[rd_addr];
  end

  // The write stage trails the read by one cycle; a reset drops any pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr_q <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      wr_addr_q <= rd_addr;
      wr_pend_q <= sweep_rd;
    end
  end

  always_comb begin
    m_bit = 1'b0;
    if (op == OP_INS) begin
      m_bit = seg_match(32'(wr_addr_q), 32'(key_s), 32'(mask_s));
    end
    wr_word     = rdata_q;
    wr_word[id] = m_bit;
    if (op == OP_CLR) begin
      wr_word = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[rd_addr] <= '0;
    end else if (wr_pend_q) begin
      mem[wr_addr_q] <= wr_word;
    end
  end

  assign rd_word = rdata_q;

endmodule

// File: rtl/seg_vector_engine_p.sv
// Segment-vector TCAM engine: NSEG banks looked up in parallel, AND-reduced
// and priority-encoded; updates sweep every bank address in hardware.
module seg_vector_engine_p
  import seg_vect_pkg::*;
#(
  parameter int NSEG    = 13,
  parameter int SEGBITS = 8,
  parameter int NENT    = 64,
  localparam int KWID   = NSEG * SEGBITS,
  localparam int IDWID  = $clog2(NENT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_srch_valid,
  output logic             o_srch_ready,
  input  logic [KWID-1:0]  i_srch_key,
  output logic             o_rslt_valid,
  output logic [NENT-1:0]  o_match_vec,
  output logic             o_hit,
  output logic [IDWID-1:0] o_hit_id,
  input  logic             i_upd_valid,
  output logic             o_upd_ready,
  input  logic [1:0]       i_upd_op,
  input  logic [IDWID-1:0] i_upd_id,
  input  logic [KWID-1:0]  i_upd_key,
  input  logic [KWID-1:0]  i_upd_mask,
  output logic             o_upd_done,
  output logic             o_busy,
  output logic [1:0]       o_dbg_state
);

  localparam logic [SEGBITS:0] CNT_LAST = (SEGBITS + 1)'(2 ** SEGBITS - 1);

  state_t             state_q, state_d;
  logic [SEGBITS:0]   cnt_q;
  logic               cnt_last;
  logic [1:0]         upd_op_q;
  logic [IDWID-1:0]   upd_id_q;
  logic [KWID-1:0]    upd_key_q;
  logic [KWID-1:0]    upd_mask_q;
  logic               srch_acc;
  logic               upd_acc;
  logic               srch_p1_q;
  logic               sweep_sel;
  logic               sweep_rd;
  logic               init_we;
  logic [NENT-1:0]    bank_word [NSEG];
  logic [NENT-1:0]    match;
  logic [IDWID-1:0]   enc_id;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready never depends on the same channel's valid, and search wins the shared read port.
  assign srch_acc = i_srch_valid && o_srch_ready;
  assign upd_acc  = i_upd_valid && o_upd_ready;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (cnt_last) state_d = IDLE;
      IDLE:    if (upd_acc)  state_d = SWEEP;
      SWEEP:   if (cnt_last) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // o_busy is held low while reset is asserted, then covers INIT, SWEEP and DRAIN.
  always_comb begin
    o_srch_ready = (state_q == IDLE);
    o_upd_ready  = (state_q == IDLE) && !i_srch_valid;
    o_busy       = rst && (state_q != IDLE);
    sweep_sel    = (state_q != IDLE);
    sweep_rd     = (state_q == SWEEP);
    init_we      = (state_q == INIT);
    o_dbg_state  = state_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == INIT) begin
      cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
    end else if (state_q == SWEEP) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (upd_acc) begin
      cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_op_q   <= OP_INS;
      upd_id_q   <= '0;
      upd_key_q  <= '0;
      upd_mask_q <= '0;
    end else if (upd_acc) begin
      upd_op_q   <= i_upd_op;
      upd_id_q   <= i_upd_id;
      upd_key_q  <= i_upd_key;
      upd_mask_q <= i_upd_mask;
    end
  end

  for (genvar s = 0; s < NSEG; s++) begin : g_bank
    logic [SEGBITS-1:0] rd_addr;

    assign rd_addr = sweep_sel ? cnt_q[SEGBITS-1:0] : i_srch_key[s*SEGBITS +: SEGBITS];

    seg_vect_bank #(
      .SEGBITS (SEGBITS),
      .NENT    (NENT),
      .IDWID   (IDWID)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr),
      .sweep_rd (sweep_rd),
      .init_we  (init_we),
      .op       (upd_op_q),
      .id       (upd_id_q),
      .key_s    (upd_key_q[s*SEGBITS +: SEGBITS]),
      .mask_s   (upd_mask_q[s*SEGBITS +: SEGBITS]),
      .rd_word  (bank_word[s])
    );
  end

  always_comb begin
    match = '1;
    for (int s = 0; s < NSEG; s++) begin
      match = match & bank_word[s];
    end
  end

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    enc_id = '0;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (match[i]) enc_id = IDWID'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      srch_p1_q    <= 1'b0;
      o_rslt_valid <= 1'b0;
      o_match_vec  <= '0;
      o_hit        <= 1'b0;
      o_hit_id     <= '0;
      o_upd_done   <= 1'b0;
    end else begin
      srch_p1_q    <= srch_acc;
      o_rslt_valid <= srch_p1_q;
      o_upd_done   <= (state_q == DRAIN);
      if (srch_p1_q) begin
        o_match_vec <= match;
        o_hit       <= |match;
        o_hit_id    <= enc_id;
      end
    end
  end

endmodule

// File: tb/tb_seg_vector_engine_p.sv
// Directed bench for seg_vector_engine_p: init sweep, insert/delete/clear,
// ternary masks, search/update priority and reset during a sweep.
module tb_seg_vector_engine_p;

  localparam int KWID  = 104;
  localparam int NENT  = 64;
  localparam int IDWID = 6;

  localparam logic [1:0] INS = 2'b00;
  localparam logic [1:0] DEL = 2'b01;
  localparam logic [1:0] CLR = 2'b10;

  localparam logic [KWID-1:0] K1      = 104'h0102030405060708090A0B0C0D;
  localparam logic [KWID-1:0] K1_B0Z  = 104'h0102030405060708090A0B0C00;
  localparam logic [KWID-1:0] K1_B0A7 = 104'h0102030405060708090A0B0CA7;
  localparam logic [KWID-1:0] K1_B1X  = 104'h0102030405060708090A0B550D;
  localparam logic [KWID-1:0] K2      = 104'hA1B2C3D4E5F60718293A4B5C6D;
  localparam logic [KWID-1:0] M_B0    = 104'hFF;

  logic             clk;
  logic             rst;
  logic             i_srch_valid;
  logic             o_srch_ready;
  logic [KWID-1:0]  i_srch_key;
  logic             o_rslt_valid;
  logic [NENT-1:0]  o_match_vec;
  logic             o_hit;
  logic [IDWID-1:0] o_hit_id;
  logic             i_upd_valid;
  logic             o_upd_ready;
  logic [1:0]       i_upd_op;
  logic [IDWID-1:0] i_upd_id;
  logic [KWID-1:0]  i_upd_key;
  logic [KWID-1:0]  i_upd_mask;
  logic             o_upd_done;
  logic             o_busy;
  logic [1:0]       o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  seg_vector_engine_p dut (
    .clk          (clk),
    .rst          (rst),
    .i_srch_valid (i_srch_valid),
    .o_srch_ready (o_srch_ready),
    .i_srch_key   (i_srch_key),
    .o_rslt_valid (o_rslt_valid),
    .o_match_vec  (o_match_vec),
    .o_hit        (o_hit),
    .o_hit_id     (o_hit_id),
    .i_upd_valid  (i_upd_valid),
    .o_upd_ready  (o_upd_ready),
    .i_upd_op     (i_upd_op),
    .i_upd_id     (i_upd_id),
    .i_upd_key    (i_upd_key),
    .i_upd_mask   (i_upd_mask),
    .o_upd_done   (o_upd_done),
    .o_busy       (o_busy),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic search(input logic [KWID-1:0] key, input logic exp_hit,
                        input logic [IDWID-1:0] exp_id, input logic [NENT-1:0] exp_vec,
                        input string tag);
    i_srch_valid = 1'b1;
    i_srch_key   = key;
    #1;
    check({tag, "_srdy"}, 128'(o_srch_ready), 128'(1'b1));
    tick();
    i_srch_valid = 1'b0;
    check({tag, "_early"}, 128'(o_rslt_valid), 128'(1'b0));
    tick();
    check({tag, "_valid"}, 128'(o_rslt_valid), 128'(1'b1));
    check({tag, "_hit"}, 128'(o_hit), 128'(exp_hit));
    check({tag, "_id"}, 128'(o_hit_id), 128'(exp_id));
    check({tag, "_vec"}, 128'(o_match_vec), 128'(exp_vec));
  endtask

  task automatic update(input logic [1:0] op, input logic [IDWID-1:0] id,
                        input logic [KWID-1:0] key, input logic [KWID-1:0] mask,
                        input string tag);
    int n;
    i_upd_valid = 1'b1;
    i_upd_op    = op;
    i_upd_id    = id;
    i_upd_key   = key;
    i_upd_mask  = mask;
    #1;
    check({tag, "_urdy"}, 128'(o_upd_ready), 128'(1'b1));
    tick();
    i_upd_valid = 1'b0;
    check({tag, "_busy"}, 128'(o_busy), 128'(1'b1));
    check({tag, "_srdy_sweep"}, 128'(o_srch_ready), 128'(1'b0));
    n = 0;
    while (!o_upd_done && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_len"}, 128'(n), 128'(257));
    check({tag, "_idle"}, 128'(o_srch_ready), 128'(1'b1));
    tick();
    check({tag, "_done_pulse"}, 128'(o_upd_done), 128'(1'b0));
  endtask

  // Directed sequence
  initial begin
    int n;
    logic done_seen;
    rst          = 1'b0;
    i_srch_valid = 1'b0;
    i_srch_key   = '0;
    i_upd_valid  = 1'b0;
    i_upd_op     = INS;
    i_upd_id     = '0;
    i_upd_key    = '0;
    i_upd_mask   = '0;

    repeat (3) tick();
    check("rst_busy", 128'(o_busy), 128'(1'b0));
    check("rst_rvalid", 128'(o_rslt_valid), 128'(1'b0));
    check("rst_vec", 128'(o_match_vec), 128'(0));
    check("rst_done", 128'(o_upd_done), 128'(1'b0));
    check("rst_srdy", 128'(o_srch_ready), 128'(1'b0));

    rst = 1'b1;
    #1;
    check("init_busy", 128'(o_busy), 128'(1'b1));
    check("init_srdy", 128'(o_srch_ready), 128'(1'b0));
    check("init_urdy", 128'(o_upd_ready), 128'(1'b0));
    n = 0;
    while (o_busy && n < 1000) begin
      tick();
      n++;
    end
    check("init_len", 128'(n), 128'(256));
    check("init_done", 128'(o_upd_done), 128'(1'b0));
    search(K1, 1'b0, 6'd0, 64'h0, "empty");

    update(INS, 6'd5, K1, '0, "ins5");
    search(K1, 1'b1, 6'd5, 64'h20, "k1_hit5");
    search(K1_B0Z, 1'b0, 6'd0, 64'h0, "k1_b0_miss");

    update(INS, 6'd9, K1, M_B0, "ins9");
    search(K1_B0Z, 1'b1, 6'd9, 64'h200, "mask_b0_00");
    search(K1_B0A7, 1'b1, 6'd9, 64'h200, "mask_b0_a7");
    search(K1, 1'b1, 6'd5, 64'h220, "k1_5_and_9");
    search(K1_B1X, 1'b0, 6'd0, 64'h0, "mask_b1_miss");

    update(INS, 6'd3, K2, '0, "ins3");
    update(INS, 6'd7, K2, '0, "ins7");
    search(K2, 1'b1, 6'd3, 64'h88, "k2_3_and_7");
    update(DEL, 6'd3, '0, '0, "del3");
    search(K2, 1'b1, 6'd7, 64'h80, "k2_after_del");
    search(K1, 1'b1, 6'd5, 64'h220, "k1_after_del");
    update(CLR, 6'd0, '0, '0, "clr");
    search(K2, 1'b0, 6'd0, 64'h0, "k2_after_clr");
    search(K1, 1'b0, 6'd0, 64'h0, "k1_after_clr");

    // Re-inserting an ID moves it cleanly to the new key.
    update(INS, 6'd5, K1, '0, "ins5_k1");
    update(INS, 6'd5, K2, '0, "ins5_k2");
    search(K1, 1'b0, 6'd0, 64'h0, "move_old_key");
    search(K2, 1'b1, 6'd5, 64'h20, "move_new_key");

    // Search and update presented together: search first, update next cycle.
    i_srch_valid = 1'b1;
    i_srch_key   = K2;
    i_upd_valid  = 1'b1;
    i_upd_op     = INS;
    i_upd_id     = 6'd2;
    i_upd_key    = K2;
    i_upd_mask   = '0;
    #1;
    check("pri_urdy_blocked", 128'(o_upd_ready), 128'(1'b0));
    check("pri_srdy", 128'(o_srch_ready), 128'(1'b1));
    tick();
    i_srch_valid = 1'b0;
    #1;
    check("pri_urdy_free", 128'(o_upd_ready), 128'(1'b1));
    tick();
    i_upd_valid = 1'b0;
    check("pri_rvalid", 128'(o_rslt_valid), 128'(1'b1));
    check("pri_vec", 128'(o_match_vec), 128'(64'h20));
    check("pri_id", 128'(o_hit_id), 128'(6'd5));
    check("pri_busy", 128'(o_busy), 128'(1'b1));
    n = 0;
    while (!o_upd_done && n < 400) begin
      tick();
      n++;
    end
    check("pri_len", 128'(n), 128'(257));
    tick();
    search(K2, 1'b1, 6'd2, 64'h24, "k2_2_and_5");

    // Reset while the sweep is reading address 100.
    i_upd_valid = 1'b1;
    i_upd_op    = INS;
    i_upd_id    = 6'd11;
    i_upd_key   = K1;
    i_upd_mask  = '0;
    #1;
    check("abort_urdy", 128'(o_upd_ready), 128'(1'b1));
    tick();
    i_upd_valid = 1'b0;
    repeat (100) tick();
    rst = 1'b0;
    #1;
    check("abort_busy", 128'(o_busy), 128'(1'b0));
    check("abort_vec", 128'(o_match_vec), 128'(0));
    check("abort_hit", 128'(o_hit), 128'(1'b0));
    check("abort_done", 128'(o_upd_done), 128'(1'b0));
    repeat (2) tick();
    rst = 1'b1;
    #1;
    done_seen = 1'b0;
    n = 0;
    while (o_busy && n < 1000) begin
      tick();
      n++;
      done_seen = done_seen | o_upd_done;
    end
    check("reinit_len", 128'(n), 128'(256));
    repeat (300) begin
      tick();
      done_seen = done_seen | o_upd_done;
    end
    check("abort_no_done", 128'(done_seen), 128'(1'b0));
    search(K2, 1'b0, 6'd0, 64'h0, "k2_after_reinit");
    search(K1, 1'b0, 6'd0, 64'h0, "k1_after_reinit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
